// File: rtl/encoder_5_seq.sv
`default_nettype none
// ============================================================================
// Module   : encoder_5_seq
// Brief    : Serial multi-hot mask encoder. Accepts a WIDTH-bit register mask
//            and emits the index of every set bit, lowest first, one per
//            valid/ready handshake, with ordinal, last flag and done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module encoder_5_seq #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 5
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDXW-1:0]   out_idx,
    output logic [IDXW-1:0]   out_seq,
    output logic              out_last,
    output logic              done
);

    localparam logic [WIDTH-1:0] c_PEND_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IDXW-1:0]  c_SEQ_ONE  = {{(IDXW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_pend;
    logic [IDXW-1:0]   r_seq;
    logic              r_done;

    logic [IDXW-1:0]   w_low_idx;
    logic              w_one_left;
    logic              w_accept;
    logic              w_fire;

    // Priority-encode the lowest pending bit; scanning downward lets the
    // lowest set bit win. Driven only by registered state.
    always_comb begin
        w_low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_low_idx = IDXW'(i);
            end
        end
    end

    // Exactly one bit pending: non-zero and clearing the lowest bit leaves zero.
    assign w_one_left = (r_pend != '0) && ((r_pend & (r_pend - c_PEND_ONE)) == '0);

    // State register.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        w_fire      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (in_valid && (in_vec != '0)) begin
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                w_fire    = out_ready;
                if (out_ready && w_one_left) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pending mask, ordinal counter and done pulse. An empty mask or the
    // final handshake of a burst raises done for exactly one cycle; reset
    // discards a partial burst without a done pulse.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            r_pend <= '0;
            r_seq  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (w_accept && (in_vec == '0)) || (w_fire && w_one_left);
            if (w_accept) begin
                r_pend <= in_vec;
                r_seq  <= '0;
            end else if (w_fire) begin
                // Clearing the lowest set bit is the same as clearing bit out_idx.
                r_pend <= r_pend & (r_pend - c_PEND_ONE);
                r_seq  <= r_seq + c_SEQ_ONE;
            end
        end
    end

    assign out_idx  = w_low_idx;
    assign out_seq  = r_seq;
    assign out_last = w_one_left;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_encoder_5_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_encoder_5_seq
// Brief    : Scoreboard testbench for encoder_5_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_encoder_5_seq;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_vec;
    logic        in_ready;
    logic        out_valid;
    logic        out_last;
    logic        done;
    logic [4:0]  out_idx;
    logic [4:0]  out_seq;

    typedef struct packed {
        logic [4:0] idx;
        logic [4:0] seq;
        logic       last;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    encoder_5_seq #(.WIDTH(32), .IDXW(5)) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec     (in_vec),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_seq    (out_seq),
        .out_last   (out_last),
        .done       (done)
    );

    always #5 clock = ~clock;

    // Advance one cycle and settle just after the rising edge.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Expected index stream for a mask: ascending set bits, ordinal, last flag.
    task automatic push_mask(input logic [31:0] v);
        int   n;
        int   total;
        exp_t e;
        n     = 0;
        total = $countones(v);
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                e.idx  = 5'(i);
                e.seq  = 5'(n);
                e.last = (n == total - 1);
                sb.push_back(e);
                n++;
            end
        end
    endtask

    task automatic test_reset;
        ctrl_reset = 1'b1;
        in_valid   = 1'b0;
        in_vec     = '0;
        out_ready  = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({in_ready, out_valid, out_idx, out_seq, out_last, done} !== {1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: rdy=%b vld=%b idx=%0d seq=%0d last=%b done=%b, want 1 0 0 0 0 0",
                     in_ready, out_valid, out_idx, out_seq, out_last, done);
        end
        ctrl_reset = 1'b0;
        tick();
    endtask

    task automatic test_single;
        exp_t e;
        in_valid  = 1'b1;
        in_vec    = 32'h0000_0100;
        out_ready = 1'b1;
        push_mask(in_vec);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready: in_ready=%b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        in_vec   = '0;
        e = sb.pop_front();
        n_tests++;
        if ({out_valid, out_idx, out_seq, out_last} !== {1'b1, e.idx, e.seq, e.last}) begin
            n_fail++;
            $display("FAIL single_out: vld=%b idx=%0d seq=%0d last=%b want 1 %0d %0d %b",
                     out_valid, out_idx, out_seq, out_last, e.idx, e.seq, e.last);
        end
        tick();
        n_tests++;
        if ({done, in_ready, out_valid} !== 3'b110) begin
            n_fail++;
            $display("FAIL single_done: done=%b rdy=%b vld=%b want 1 1 0", done, in_ready, out_valid);
        end
    endtask

    task automatic test_stall;
        int   rp[5] = '{1, 0, 0, 1, 1};
        exp_t e;
        in_valid = 1'b1;
        in_vec   = 32'h8000_0005;
        push_mask(in_vec);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            out_ready = rp[k][0];
            e = (sb.size() != 0) ? sb[0] : '0;
            n_tests++;
            if (sb.size() == 0 || {out_valid, out_idx, out_seq, out_last, done} !== {1'b1, e.idx, e.seq, e.last, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_c%0d: vld=%b idx=%0d seq=%0d last=%b done=%b want 1 %0d %0d %b 0",
                         k, out_valid, out_idx, out_seq, out_last, done, e.idx, e.seq, e.last);
            end
            if (out_ready) begin
                void'(sb.pop_front());
            end
            tick();
        end
        n_tests++;
        if ({done, out_valid, in_ready} !== 3'b101 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL stall_done: done=%b vld=%b rdy=%b left=%0d want 1 0 1 0",
                     done, out_valid, in_ready, sb.size());
        end
        tick();
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_pulse: done=%b want 0", done);
        end
    endtask

    task automatic test_full;
        exp_t e;
        in_valid  = 1'b1;
        in_vec    = 32'hFFFF_FFFF;
        out_ready = 1'b1;
        push_mask(in_vec);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            e = (sb.size() != 0) ? sb.pop_front() : '0;
            n_tests++;
            if ({out_valid, out_idx, out_seq, out_last, done} !== {1'b1, e.idx, e.seq, e.last, 1'b0}) begin
                n_fail++;
                $display("FAIL full_i%0d: vld=%b idx=%0d seq=%0d last=%b done=%b want 1 %0d %0d %b 0",
                         k, out_valid, out_idx, out_seq, out_last, done, e.idx, e.seq, e.last);
            end
            tick();
        end
        n_tests++;
        if ({done, out_valid, in_ready} !== 3'b101) begin
            n_fail++;
            $display("FAIL full_done: done=%b vld=%b rdy=%b want 1 0 1", done, out_valid, in_ready);
        end
        tick();
    endtask

    task automatic test_empty;
        in_valid = 1'b1;
        in_vec   = '0;
        tick();
        in_valid = 1'b0;
        n_tests++;
        if ({done, in_ready, out_valid} !== 3'b110) begin
            n_fail++;
            $display("FAIL empty_done: done=%b rdy=%b vld=%b want 1 1 0", done, in_ready, out_valid);
        end
        tick();
        n_tests++;
        if ({done, in_ready, out_valid} !== 3'b010) begin
            n_fail++;
            $display("FAIL empty_after: done=%b rdy=%b vld=%b want 0 1 0", done, in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        in_valid  = 1'b1;
        in_vec    = 32'h0000_00F0;
        out_ready = 1'b1;
        push_mask(in_vec);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            e = (sb.size() != 0) ? sb.pop_front() : '0;
            n_tests++;
            if ({out_valid, out_idx, out_seq} !== {1'b1, e.idx, e.seq}) begin
                n_fail++;
                $display("FAIL rstmid_i%0d: vld=%b idx=%0d seq=%0d want 1 %0d %0d",
                         k, out_valid, out_idx, out_seq, e.idx, e.seq);
            end
            tick();
        end
        ctrl_reset = 1'b1;
        tick();
        ctrl_reset = 1'b0;
        sb.delete();
        n_tests++;
        if ({in_ready, out_valid, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL rstmid_state: rdy=%b vld=%b done=%b want 1 0 0", in_ready, out_valid, done);
        end
        in_valid = 1'b1;
        in_vec   = 32'h0000_0001;
        push_mask(in_vec);
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_nodone: done=%b want 0", done);
        end
        e = sb.pop_front();
        n_tests++;
        if ({out_valid, out_idx, out_seq, out_last} !== {1'b1, e.idx, e.seq, e.last}) begin
            n_fail++;
            $display("FAIL rstmid_new: vld=%b idx=%0d seq=%0d last=%b want 1 %0d %0d %b",
                     out_valid, out_idx, out_seq, out_last, e.idx, e.seq, e.last);
        end
        tick();
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_done: done=%b want 1", done);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        in_valid  = 1'b1;
        in_vec    = 32'h0000_0003;
        out_ready = 1'b1;
        push_mask(in_vec);
        tick();
        in_vec = 32'h0000_0004;
        for (int k = 0; k < 2; k++) begin
            e = (sb.size() != 0) ? sb.pop_front() : '0;
            n_tests++;
            if ({in_ready, out_valid, out_idx, out_seq, out_last} !== {1'b0, 1'b1, e.idx, e.seq, e.last}) begin
                n_fail++;
                $display("FAIL b2b_i%0d: rdy=%b vld=%b idx=%0d seq=%0d last=%b want 0 1 %0d %0d %b",
                         k, in_ready, out_valid, out_idx, out_seq, out_last, e.idx, e.seq, e.last);
            end
            tick();
        end
        n_tests++;
        if ({done, in_ready, out_valid} !== 3'b110) begin
            n_fail++;
            $display("FAIL b2b_done: done=%b rdy=%b vld=%b want 1 1 0", done, in_ready, out_valid);
        end
        push_mask(in_vec);
        tick();
        in_valid = 1'b0;
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        n_tests++;
        if ({out_valid, out_idx, out_seq, out_last, done} !== {1'b1, e.idx, e.seq, e.last, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_second: vld=%b idx=%0d seq=%0d last=%b done=%b want 1 %0d %0d %b 0",
                     out_valid, out_idx, out_seq, out_last, done, e.idx, e.seq, e.last);
        end
        tick();
        n_tests++;
        if ({done, in_ready, out_valid} !== 3'b110 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_done2: done=%b rdy=%b vld=%b left=%0d want 1 1 0 0",
                     done, in_ready, out_valid, sb.size());
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_full();
        test_empty();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
